// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: decode-stage instruction fields and the branch
// outcome go in, pipeline control and forwarding selects come out.
//   master : pipeline side (drives ID fields and br_taken, reads controls)
//   slave  : hazard_ctrl (reads ID fields and br_taken, drives controls)
// REG_ADDR_W and CNT_W must match the parameters of the attached hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rn;
    logic [REG_ADDR_W-1:0] id_rm;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_uses_rn;
    logic                  id_uses_rm;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  br_taken;

    logic                  stall_if;
    logic                  bubble_ex;
    logic                  flush;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output id_valid, id_rn, id_rm, id_rd, id_uses_rn, id_uses_rm,
               id_reg_write, id_mem_read, br_taken,
        input  stall_if, bubble_ex, flush, fwd_a, fwd_b,
               stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rd, id_uses_rn, id_uses_rm,
               id_reg_write, id_mem_read, br_taken,
        output stall_if, bubble_ex, flush, fwd_a, fwd_b,
               stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and flush controller for a five-stage LEGv8 pipeline.
// Tracks the instructions in EX, MEM and WB, detects RAW / load-use hazards
// against the decode instruction, and drives stall, bubble, flush and the
// ALU operand forwarding selects. Saturating counters record stall cycles
// and taken-branch flushes.
// Ports:
//   clk    : pipeline clock, rising edge
//   reset  : asynchronous, active-high; clears all state and forces outputs low
//   bus    : hazard_ctrl_if.slave (ID fields, br_taken in; controls out)
module hazard_ctrl #(
    parameter int WORD           = 64,
    parameter int REG_ADDR_W     = 5,
    parameter int ZERO_REG       = 31,
    parameter int HAS_FORWARDING = 1,
    parameter int CNT_W          = 16
) (
    input  logic           clk,
    input  logic           reset,
    hazard_ctrl_if.slave   bus
);

    localparam logic [REG_ADDR_W-1:0] XZR     = REG_ADDR_W'(ZERO_REG);
    localparam logic [CNT_W-1:0]      CNT_MAX = '1;
    // A degenerate datapath width has nothing to forward, so it falls back
    // to stall-only operation.
    localparam bit FWD_EN = (HAS_FORWARDING != 0) && (WORD > 0);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    // EX keeps its sources for forwarding; MEM and WB are only ever compared
    // as producers, so they carry just the writer fields.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rn;
        logic [REG_ADDR_W-1:0] rm;
        logic                  reg_write;
        logic                  mem_read;
        logic                  uses_rn;
        logic                  uses_rm;
    } ex_slot_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } wr_slot_t;

    ex_slot_t ex_q;
    ex_slot_t id_slot;
    wr_slot_t mem_q;
    wr_slot_t wb_q;

    logic hz_ex;
    logic hz_mem;
    logic hz_wb;
    logic hazard;
    logic stall;
    logic br;

    function automatic logic match(
        input logic                  valid,
        input logic                  reg_write,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] r,
        input logic                  u
    );
        return u && (r != XZR) && valid && reg_write && (rd != XZR) && (rd == r);
    endfunction

    function automatic logic [1:0] fwd_sel(
        input ex_slot_t              ex,
        input wr_slot_t              mem,
        input wr_slot_t              wb,
        input logic [REG_ADDR_W-1:0] r,
        input logic                  u
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (FWD_EN && ex.valid) begin
            if (match(mem.valid, mem.reg_write, mem.rd, r, u))
                sel = SEL_MEM;
            else if (match(wb.valid, wb.reg_write, wb.rd, r, u))
                sel = SEL_WB;
        end
        return sel;
    endfunction

    always_comb begin
        id_slot = '0;
        if (bus.id_valid) begin
            id_slot.valid     = 1'b1;
            id_slot.rd        = bus.id_rd;
            id_slot.rn        = bus.id_rn;
            id_slot.rm        = bus.id_rm;
            id_slot.reg_write = bus.id_reg_write;
            id_slot.mem_read  = bus.id_mem_read;
            id_slot.uses_rn   = bus.id_uses_rn;
            id_slot.uses_rm   = bus.id_uses_rm;
        end
    end

    always_comb begin
        hz_ex  = match(ex_q.valid, ex_q.reg_write, ex_q.rd, id_slot.rn, id_slot.uses_rn)
              || match(ex_q.valid, ex_q.reg_write, ex_q.rd, id_slot.rm, id_slot.uses_rm);
        hz_mem = match(mem_q.valid, mem_q.reg_write, mem_q.rd, id_slot.rn, id_slot.uses_rn)
              || match(mem_q.valid, mem_q.reg_write, mem_q.rd, id_slot.rm, id_slot.uses_rm);
        hz_wb  = match(wb_q.valid, wb_q.reg_write, wb_q.rd, id_slot.rn, id_slot.uses_rn)
              || match(wb_q.valid, wb_q.reg_write, wb_q.rd, id_slot.rm, id_slot.uses_rm);
        // With forwarding, only a load in EX or a producer in WB (the register
        // file does not bypass its own write) can block decode.
        if (FWD_EN)
            hazard = (hz_ex && ex_q.mem_read) || hz_wb;
        else
            hazard = hz_ex || hz_mem || hz_wb;
    end

    // Reset gates the outputs so they drop without waiting for a clock edge.
    assign br    = bus.br_taken && !reset;
    assign stall = bus.id_valid && hazard && !bus.br_taken && !reset;

    assign bus.stall_if  = stall;
    assign bus.bubble_ex = stall;
    assign bus.flush     = br;
    assign bus.fwd_a     = fwd_sel(ex_q, mem_q, wb_q, ex_q.rn, ex_q.uses_rn);
    assign bus.fwd_b     = fwd_sel(ex_q, mem_q, wb_q, ex_q.rm, ex_q.uses_rm);

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            wb_q <= mem_q;
            if (br) begin
                mem_q <= '0;
            end else begin
                mem_q.valid     <= ex_q.valid;
                mem_q.rd        <= ex_q.rd;
                mem_q.reg_write <= ex_q.reg_write;
            end
            ex_q <= (br || stall) ? '0 : id_slot;
            if (stall && stall_cnt_q != CNT_MAX)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (br && flush_cnt_q != CNT_MAX)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic [4:0] id_rd;
    logic       id_uses_rn;
    logic       id_uses_rm;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       br_taken;

    int n_total;
    int n_bad;

    hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus_f ();
    hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4))  bus_s ();

    hazard_ctrl #(.WORD(64), .REG_ADDR_W(5), .ZERO_REG(31), .HAS_FORWARDING(1), .CNT_W(16))
        u_fwd (.clk(clk), .reset(reset), .bus(bus_f));
    hazard_ctrl #(.WORD(64), .REG_ADDR_W(5), .ZERO_REG(31), .HAS_FORWARDING(0), .CNT_W(4))
        u_stl (.clk(clk), .reset(reset), .bus(bus_s));

    assign bus_f.id_valid     = id_valid;
    assign bus_f.id_rn        = id_rn;
    assign bus_f.id_rm        = id_rm;
    assign bus_f.id_rd        = id_rd;
    assign bus_f.id_uses_rn   = id_uses_rn;
    assign bus_f.id_uses_rm   = id_uses_rm;
    assign bus_f.id_reg_write = id_reg_write;
    assign bus_f.id_mem_read  = id_mem_read;
    assign bus_f.br_taken     = br_taken;

    assign bus_s.id_valid     = id_valid;
    assign bus_s.id_rn        = id_rn;
    assign bus_s.id_rm        = id_rm;
    assign bus_s.id_rd        = id_rd;
    assign bus_s.id_uses_rn   = id_uses_rn;
    assign bus_s.id_uses_rm   = id_uses_rm;
    assign bus_s.id_reg_write = id_reg_write;
    assign bus_s.id_mem_read  = id_mem_read;
    assign bus_s.br_taken     = br_taken;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic [4:0] rn,
                          input logic [4:0] rm, input logic un, input logic um,
                          input logic rw, input logic mr);
        id_valid = v; id_rd = rd; id_rn = rn; id_rm = rm;
        id_uses_rn = un; id_uses_rm = um; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
        set_id(1'b1, rd, rn, rm, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic ldur(input logic [4:0] rd, input logic [4:0] rn);
        set_id(1'b1, rd, rn, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        br_taken = 1'b0;
        nop();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        reset = 1'b1;
        br_taken = 1'b0;
        nop();

        // reset state
        #3;
        check("rst_stall_if", bus_f.stall_if, 0);
        check("rst_bubble", bus_f.bubble_ex, 0);
        check("rst_flush", bus_f.flush, 0);
        check("rst_fwd_a", bus_f.fwd_a, 0);
        check("rst_fwd_b", bus_f.fwd_b, 0);
        check("rst_stall_cnt", bus_f.stall_count, 0);
        check("rst_flush_cnt", bus_s.flush_count, 0);

        // load-use with forwarding: LDUR X2 ; ADD X3,X2,X4
        do_reset();
        ldur(5'd2, 5'd1);
        #1 check("lu_first", bus_f.stall_if, 0);
        tick(); alu(5'd3, 5'd2, 5'd4);
        #1 check("lu_stall", bus_f.stall_if, 1);
        check("lu_bubble", bus_f.bubble_ex, 1);
        tick();
        #1 check("lu_release", bus_f.stall_if, 0);
        tick(); nop();
        #1 check("lu_fwd_a", bus_f.fwd_a, 2'b01);
        check("lu_fwd_b", bus_f.fwd_b, 2'b00);
        check("lu_cnt", bus_f.stall_count, 1);

        // back-to-back ALU: ADD X1 ; SUB X5,X1,X1
        do_reset();
        alu(5'd1, 5'd2, 5'd3);
        tick(); alu(5'd5, 5'd1, 5'd1);
        #1 check("b2b_nostall", bus_f.stall_if, 0);
        tick(); nop();
        #1 check("b2b_fwd_a", bus_f.fwd_a, 2'b10);
        check("b2b_fwd_b", bus_f.fwd_b, 2'b10);

        // one independent instruction in between
        do_reset();
        alu(5'd1, 5'd2, 5'd3);
        tick(); alu(5'd7, 5'd8, 5'd9);
        tick(); alu(5'd5, 5'd1, 5'd1);
        #1 check("gap1_nostall", bus_f.stall_if, 0);
        tick(); nop();
        #1 check("gap1_fwd_a", bus_f.fwd_a, 2'b01);
        check("gap1_fwd_b", bus_f.fwd_b, 2'b01);

        // producer three ahead: in WB while the consumer decodes
        do_reset();
        alu(5'd1, 5'd2, 5'd3);
        tick(); alu(5'd7, 5'd8, 5'd9);
        tick(); alu(5'd10, 5'd8, 5'd9);
        tick(); alu(5'd5, 5'd1, 5'd1);
        #1 check("gap2_stall", bus_f.stall_if, 1);
        tick();
        #1 check("gap2_release", bus_f.stall_if, 0);
        tick(); nop();
        #1 check("gap2_fwd_a", bus_f.fwd_a, 2'b00);
        check("gap2_cnt", bus_f.stall_count, 1);

        // XZR producer never creates a hazard or a forward
        do_reset();
        alu(5'd31, 5'd2, 5'd3);
        tick(); alu(5'd4, 5'd31, 5'd31);
        #1 check("xzr_stall_f", bus_f.stall_if, 0);
        check("xzr_stall_s", bus_s.stall_if, 0);
        tick(); nop();
        #1 check("xzr_fwd_a_f", bus_f.fwd_a, 0);
        check("xzr_fwd_b_f", bus_f.fwd_b, 0);
        check("xzr_fwd_a_s", bus_s.fwd_a, 0);

        // taken branch in the same cycle as a load-use hazard
        do_reset();
        ldur(5'd2, 5'd1);
        tick(); alu(5'd3, 5'd2, 5'd4); br_taken = 1'b1;
        #1 check("br_flush", bus_f.flush, 1);
        check("br_stall_if", bus_f.stall_if, 0);
        check("br_bubble", bus_f.bubble_ex, 0);
        tick(); br_taken = 1'b0; alu(5'd3, 5'd2, 5'd4);
        #1 check("br_killed_nostall", bus_f.stall_if, 0);
        check("br_flush_drop", bus_f.flush, 0);
        tick(); nop();
        #1 check("br_fwd_a", bus_f.fwd_a, 0);
        check("br_flush_cnt", bus_f.flush_count, 1);
        check("br_stall_cnt", bus_f.stall_count, 0);

        // stall-only mode: ADD X1 ; ADD X2,X1,X1 -> 3 stall cycles
        do_reset();
        alu(5'd1, 5'd2, 5'd3);
        tick(); alu(5'd2, 5'd1, 5'd1);
        for (int i = 0; i < 3; i++) begin
            #1 check("so_stall", bus_s.stall_if, 1);
            check("so_fwd_a", bus_s.fwd_a, 0);
            tick();
        end
        #1 check("so_release", bus_s.stall_if, 0);
        tick(); nop();
        #1 check("so_fwd_a_ex", bus_s.fwd_a, 0);
        check("so_fwd_b_ex", bus_s.fwd_b, 0);
        check("so_cnt", bus_s.stall_count, 3);

        // reset asserted mid-stall, then normal load after release
        do_reset();
        alu(5'd1, 5'd2, 5'd3);
        tick(); alu(5'd2, 5'd1, 5'd1);
        tick();
        #1 check("mr_stall", bus_s.stall_if, 1);
        check("mr_cnt_before", bus_s.stall_count, 1);
        reset = 1'b1;
        #1 check("mr_stall_async", bus_s.stall_if, 0);
        check("mr_bubble_async", bus_s.bubble_ex, 0);
        check("mr_cnt_async", bus_s.stall_count, 0);
        @(negedge clk); reset = 1'b0;
        #1 check("mr_after_nostall", bus_s.stall_if, 0);
        tick(); alu(5'd4, 5'd2, 5'd2);
        #1 check("mr_loaded", bus_s.stall_if, 1);

        // saturation with CNT_W=4: 18 stall cycles in 24 edges
        do_reset();
        alu(5'd1, 5'd1, 5'd1);
        repeat (16) @(posedge clk);
        #2 check("sat_mid", bus_s.stall_count, 12);
        repeat (8) @(posedge clk);
        #2 check("sat_stick", bus_s.stall_count, 15);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
